// File: rtl/ifetch_queue_pkg.sv
// Shared types for the decoupled instruction-fetch front end:
// queue entry layout, fetch FSM encoding and the ibus request/response bundles.
package ifetch_queue_pkg;

  // One queued instruction together with the address it was fetched from.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FQ_IDLE = 2'd0,
    FQ_REQ  = 2'd1,
    FQ_WAIT = 2'd2
  } fq_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  localparam logic [63:0] INSTR_BYTES = 64'd4;

  // Sequential fetch step; compressed instructions are not supported here.
  function automatic logic [63:0] next_seq_pc(input logic [63:0] pc);
    return pc + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/ifetch_queue_fifo.sv
// Generic synchronous FIFO with single-cycle flush. Head data is combinational
// from storage. Callers are expected to never push into a full FIFO; the fetch
// FSM guarantees this by reserving a slot before it issues a request.
module sync_fifo
  import ifetch_queue_pkg::*;
#(
  parameter type T     = fetch_entry_t,
  parameter int  DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output T                       head
);

  localparam int PW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [PW-1:0]  head_ptr;
  logic [PW-1:0]  tail_ptr;
  logic           do_push;
  logic           do_pop;

  // Flush wins over both push and pop; popping an empty FIFO is a no-op.
  assign do_push = push && !flush;
  assign do_pop  = pop && (count != '0) && !flush;

  assign head = mem[head_ptr];

  // Storage array; no reset needed because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= tail_ptr;
      count    <= '0;
    end else begin
      if (do_push) begin
        tail_ptr <= tail_ptr + 1'b1;
      end
      if (do_pop) begin
        head_ptr <= head_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Decoupled instruction-fetch front end: PC generator, ibus request FSM and an
// instruction queue between the ibus and decode. Redirects flush the queue and
// mark any still-outstanding bus response as stale so it is discarded.
//
// state   | meaning
// --------+-------------------------------------------------------------
// FQ_IDLE | no bus transaction; issue next request when a slot is free
// FQ_REQ  | ireq.valid high, address held stable until addr_ok
// FQ_WAIT | address accepted, waiting for data_ok
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] PC_RESET = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  localparam int                CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);

  fq_state_t     state;
  fq_state_t     state_nxt;
  logic [63:0]   fetch_pc;
  logic [63:0]   fetch_pc_nxt;
  logic [63:0]   req_addr;
  logic          drop;
  logic          drop_nxt;
  logic          resp_done;
  logic          still_inflight;
  logic          slots_free;
  logic          push;
  logic          pop;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  // Only IDLE issues, and nothing is in flight there, so occupancy alone decides.
  // A pop this cycle frees its slot for the following cycle.
  assign slots_free = (count < DEPTH_C);

  assign push_entry = '{pc: fetch_pc, instr: iresp.data};

  // A pop that coincides with a redirect is ignored: the whole queue is flushed.
  assign pop = out_valid && out_ready && !redirect;

  sync_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .count     (count),
    .head      (head)
  );

  // Next-state, response handling and redirect bookkeeping.
  always_comb begin
    state_nxt      = state;
    fetch_pc_nxt   = fetch_pc;
    drop_nxt       = drop;
    push           = 1'b0;
    resp_done      = 1'b0;
    still_inflight = 1'b0;

    case (state)
      FQ_IDLE: begin
        if (slots_free) begin
          state_nxt = FQ_REQ;
        end
      end
      FQ_REQ: begin
        if (iresp.addr_ok) begin
          if (iresp.data_ok) begin
            resp_done = 1'b1;
            state_nxt = FQ_IDLE;
          end else begin
            state_nxt = FQ_WAIT;
          end
        end
      end
      FQ_WAIT: begin
        if (iresp.data_ok) begin
          resp_done = 1'b1;
          state_nxt = FQ_IDLE;
        end
      end
      default: begin
        state_nxt = FQ_IDLE;
      end
    endcase

    // A transaction survives this cycle if we are on the bus and it did not complete.
    still_inflight = ((state == FQ_REQ) || (state == FQ_WAIT)) && !resp_done;

    if (redirect) begin
      // Data completing in the redirect cycle is simply not pushed; anything
      // still outstanding afterwards is stale and must be swallowed later.
      fetch_pc_nxt = redirect_pc;
      drop_nxt     = still_inflight;
    end else if (resp_done) begin
      if (drop) begin
        drop_nxt = 1'b0;
      end else begin
        push         = 1'b1;
        fetch_pc_nxt = next_seq_pc(fetch_pc);
      end
    end
  end

  // State, PC and drop registers; req_addr is captured on entry to REQ so the
  // bus address stays stable even if a redirect moves fetch_pc mid-request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FQ_IDLE;
      fetch_pc <= PC_RESET;
      drop     <= 1'b0;
      req_addr <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      drop     <= drop_nxt;
      if ((state == FQ_IDLE) && (state_nxt == FQ_REQ)) begin
        req_addr <= fetch_pc_nxt;
      end
    end
  end

  // Bus request and decode-side outputs; head fields are zeroed while empty.
  always_comb begin
    ireq       = '0;
    ireq.valid = (state == FQ_REQ);
    ireq.addr  = req_addr;
    out_valid  = (count != '0);
    out_pc     = out_valid ? head.pc    : 64'd0;
    out_instr  = out_valid ? head.instr : 32'd0;
  end

endmodule
